spi_slave: RTL and testbench
============================

# spi_slave

SPI slave endpoint that answers the SPI master on the same bus. It receives a `bits_size`-bit MSB-first word on MOSI and returns a preloaded word on MISO, for all four SPI modes. The block is oversampled by the local system clock: SCLK, SS_n and MOSI are asynchronous inputs that it synchronizes and edge-detects internally. It sits at the peripheral side of the bus and hands complete words to local logic with a one-cycle done strobe.

## Interface
- `mode`, 2'b00: SPI mode {CPOL,CPHA}; must match the master.
- `bits_size`, 10: word length in bits, ≥2.
- `clk`  in  1  system clock; must run ≥8× SCLK frequency.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  bits_size  word to transmit; sampled at frame start and at each word boundary.
- `data_out`  out  bits_size  last complete received word; held until the next complete word.
- `rx_done`  out  1  one-cycle pulse when `data_out` updates.
- `tx_load`  out  1  one-cycle pulse when `data_in` is captured; local logic presents the next word before the next boundary.
- `busy`  out  1  high while SS_n is (synchronized) low.
- `frame_err`  out  1  one-cycle pulse when SS_n rises with a partial word.
- `sclk`  in  1  bus clock from master (async).
- `ss_n`  in  1  slave select, active low (async).
- `mosi`  in  1  master-out data (async).
- `miso`  out  1  slave-out data.
- `miso_oe`  out  1  MISO output enable; high only while selected.

## Operation
- Input conditioning: `sclk`, `ss_n`, `mosi` each pass through a 2-flop synchronizer; a third register on sync SCLK/SS_n forms rise/fall pulses. Leading edge = rise if CPOL=0, fall if CPOL=1; trailing edge = the opposite.
- FSM states: IDLE, SHIFT.
  - IDLE: `busy`=0, `miso_oe`=0. On sync SS_n fall: load shift register from `data_in`, pulse `tx_load`, clear bit counter, go to SHIFT. If CPHA=0, drive `miso` = data_in[bits_size-1] in the same cycle.
  - SHIFT, CPHA=0: sample sync MOSI on leading edge; shift out the next bit on trailing edge.
  - SHIFT, CPHA=1: shift out a bit on leading edge (the first leading edge drives the MSB); sample on trailing edge.
  - Bit counter counts sampled bits, 0..bits_size-1. At the bits_size-th sample: `data_out` ← assembled word, pulse `rx_done`, counter wraps to 0.
  - Back-to-back words (SS_n held low): at the wrap, reload shift register from `data_in` and pulse `tx_load`; for CPHA=0, MSB of the new word drives on the trailing edge that follows the final sample.
  - Sync SS_n rise → IDLE, `miso_oe`=0. If counter ≠ 0, pulse `frame_err`; `data_out` is unchanged and no `rx_done` fires.
- SCLK edges while in IDLE are ignored. A SS_n fall and rise in the same synchronized cycle cannot occur; a rise and an SCLK edge in the same cycle: the SS_n rise wins and the edge is discarded.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `data_out`=0, `rx_done`=0, `tx_load`=0, `busy`=0, `frame_err`=0, FSM=IDLE, counter=0.
- Edge-pulse latency: 3 clk after the pin transition (2 sync + 1 detect). All actions follow the detect cycle by one registered clk.
- MISO update lags the launching SCLK edge by ≤4 clk; the master samples half an SCLK period later, hence the ≥8× ratio.
- `rx_done` asserts 1 clk after the detect of the final sampling edge.
- Reset mid-frame: immediate return to reset values; no `rx_done` or `frame_err` is emitted.

## Structure
- Shared package `spi_pkg`: mode constants MODE0..MODE3 and functions `cpol(mode)`/`cpha(mode)`. The SPI master uses the same package.
- One sub-module, `spi_sync_edge`: a 2-flop synchronizer plus rise/fall detector, instantiated for sclk and ss_n. MOSI uses the synchronizer only.

## Test plan
- Mode 0, bits_size=10: the master sends 10'h2A5 while `data_in`=10'h15A → `data_out`=10'h2A5, a single `rx_done` pulse, and the master receives 10'h15A.
- Mode 3: the same values → same result; MISO changes only on falling SCLK edges and stays stable across rising edges.
- Modes 1 and 2: the master sends 10'h3FF and 10'h001 → exact match in both directions.
- Back-to-back in mode 0 with SS_n held low: words 10'h111 then 10'h222, `data_in` changed after the first `tx_load` → two `rx_done` pulses and two `tx_load` pulses; both words are correct in both directions.
- Abort: SS_n rises after 6 of 10 bits → `frame_err` pulses once, `data_out` keeps its previous value, `busy`=0 and `miso_oe`=0 within 4 clk.
- Reset: `reset_n` asserted mid-frame → all outputs return to reset values at once; the next full frame 10'h0F0 is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, mode decode helpers and the slave FSM state type.
// Used by both the SPI master and the SPI slave.
package spi_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI bus pins between one master and one slave endpoint.
interface spi_slave_if;
  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output ss_n, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input ss_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a third stage that turns
// the synchronized level into single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  // Stages [0],[1] synchronize; [2] holds the previous synchronized level.
  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q <= {3{RESET_VAL}};
    end else begin
      sh_q <= {sh_q[1:0], d_i};
    end
  end

  assign rise_o =  sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] &  sh_q[2];

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI slave: synchronizes the bus pins to clk, shifts a MSB-first
// word in on MOSI and a preloaded word out on MISO, in any of the four SPI modes.
module spi_slave
  import spi_pkg::*;
#(
  parameter logic [1:0] MODE      = MODE0,
  parameter int         BITS_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BITS_SIZE-1:0] data_in,
  output logic [BITS_SIZE-1:0] data_out,
  output logic                 rx_done,
  output logic                 tx_load,
  output logic                 busy,
  output logic                 frame_err,
  spi_slave_if.slave           bus
);

  localparam int                CW    = $clog2(BITS_SIZE);
  localparam logic [CW-1:0]     LAST  = CW'(BITS_SIZE - 1);
  localparam logic              CPOL  = cpol(MODE);
  localparam logic              CPHA  = cpha(MODE);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [1:0] mosi_sync_q;
  logic mosi_s;

  // SCLK idles at CPOL, SS_n idles high: resetting to those levels avoids a
  // phantom edge right after reset.
  spi_sync_edge #(.RESET_VAL(CPOL)) u_sclk_sync (
    .clk(clk), .reset_n(reset_n), .d_i(bus.sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .reset_n(reset_n), .d_i(bus.ss_n), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mosi_sync_q <= 2'b00;
    end else begin
      mosi_sync_q <= {mosi_sync_q[0], bus.mosi};
    end
  end
  assign mosi_s = mosi_sync_q[1];

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  spi_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BITS_SIZE-1:0]  tx_q, tx_d;
  logic [BITS_SIZE-2:0]  rx_q, rx_d;
  logic [BITS_SIZE-1:0]  data_out_q, data_out_d;
  logic                  rx_done_q, rx_done_d;
  logic                  tx_load_q, tx_load_d;
  logic                  frame_err_q, frame_err_d;
  logic                  miso_q, miso_d;
  logic [BITS_SIZE-1:0]  rx_word;

  assign rx_word = {rx_q, mosi_s};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      data_out_q  <= '0;
      rx_done_q   <= 1'b0;
      tx_load_q   <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      data_out_q  <= data_out_d;
      rx_done_q   <= rx_done_d;
      tx_load_q   <= tx_load_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    data_out_d  = data_out_q;
    rx_done_d   = 1'b0;
    tx_load_d   = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = miso_q;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d   = ST_SHIFT;
          cnt_d     = '0;
          tx_load_d = 1'b1;
          // With CPHA=0 the MSB must already be on MISO before the first edge.
          if (!CPHA) begin
            miso_d = data_in[BITS_SIZE-1];
            tx_d   = {data_in[BITS_SIZE-2:0], 1'b0};
          end else begin
            tx_d   = data_in;
          end
        end
      end

      ST_SHIFT: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (cnt_q != '0) begin
            frame_err_d = 1'b1;
          end
        end else begin
          if (shift_edge) begin
            miso_d = tx_q[BITS_SIZE-1];
            tx_d   = {tx_q[BITS_SIZE-2:0], 1'b0};
          end
          if (sample_edge) begin
            rx_d = rx_word[BITS_SIZE-2:0];
            if (cnt_q == LAST) begin
              // Word boundary: publish the received word and queue the next one,
              // whose MSB goes out on the following shift edge.
              cnt_d      = '0;
              data_out_d = rx_word;
              rx_done_d  = 1'b1;
              tx_d       = data_in;
              tx_load_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign data_out    = data_out_q;
  assign rx_done     = rx_done_q;
  assign tx_load     = tx_load_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q == ST_SHIFT);
  assign bus.miso    = miso_q;
  assign bus.miso_oe = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one slave per SPI mode on a shared behavioural
// master, table-driven single-word frames plus back-to-back, abort and reset sequences.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int H = 8;  // clk cycles per SCLK half period

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] din = 10'h000;
  logic       sclk_n = 1'b0;   // 1 = leading half of the SCLK period
  logic       ss_n_m = 1'b1;
  logic       mosi_m = 1'b0;
  logic [1:0] sel = 2'd0;

  logic [9:0] dout_v [4];
  logic       rxd_v  [4];
  logic       txl_v  [4];
  logic       busy_v [4];
  logic       fer_v  [4];
  logic       miso_v [4];
  logic       oe_v   [4];
  logic       miso_m;

  int rxd_n [4] = '{default: 0};
  int txl_n [4] = '{default: 0};
  int fer_n [4] = '{default: 0};
  logic [9:0] hist0 = '0, hist1 = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_slave_if bus [4] ();

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam logic [1:0] M = 2'(gi);
    assign bus[gi].sclk = sclk_n ^ cpol(M);
    assign bus[gi].ss_n = (sel == M) ? ss_n_m : 1'b1;
    assign bus[gi].mosi = mosi_m;
    assign miso_v[gi]   = bus[gi].miso;
    assign oe_v[gi]     = bus[gi].miso_oe;

    spi_slave #(.MODE(M), .BITS_SIZE(10)) u_dut (
      .clk(clk), .reset_n(reset_n), .data_in(din), .data_out(dout_v[gi]),
      .rx_done(rxd_v[gi]), .tx_load(txl_v[gi]), .busy(busy_v[gi]),
      .frame_err(fer_v[gi]), .bus(bus[gi])
    );
  end

  assign miso_m = miso_v[sel];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rxd_v[k]) rxd_n[k] <= rxd_n[k] + 1;
      if (txl_v[k]) txl_n[k] <= txl_n[k] + 1;
      if (fer_v[k]) fer_n[k] <= fer_n[k] + 1;
    end
    if (rxd_v[0]) begin
      hist0 <= hist1;
      hist1 <= dout_v[0];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural master: shifts nbits of tx MSB-first, collects MISO into rx.
  task automatic spi_xfer(input logic [1:0] m, input int nbits, input logic [19:0] tx,
                          input bit keep_sel, output logic [19:0] rx);
    logic b;
    rx     = '0;
    sel    = m;
    mosi_m = tx[nbits-1];
    ss_n_m = 1'b0;
    tick(H);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha(m)) begin
        sclk_n = 1'b1;
        rx = {rx[18:0], miso_m};
        tick(H);
        sclk_n = 1'b0;
        if (i > 0) mosi_m = tx[i-1];
        tick(H);
      end else begin
        sclk_n = 1'b1;
        mosi_m = tx[i];
        tick(H);
        sclk_n = 1'b0;
        b  = miso_m;
        rx = {rx[18:0], b};
        tick(6);
        check("miso_stable", {31'd0, miso_m}, {31'd0, b});
        tick(H - 6);
      end
    end
    if (!keep_sel) ss_n_m = 1'b1;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [9:0] mtx;
    logic [9:0] din;
    logic [9:0] exp_dout;
    logic [9:0] exp_mrx;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [19:0] rx;
    int r0, t0, f0;

    vecs[0] = '{2'd0, 10'h2A5, 10'h15A, 10'h2A5, 10'h15A};
    vecs[1] = '{2'd3, 10'h2A5, 10'h15A, 10'h2A5, 10'h15A};
    vecs[2] = '{2'd1, 10'h3FF, 10'h001, 10'h3FF, 10'h001};
    vecs[3] = '{2'd1, 10'h001, 10'h3FF, 10'h001, 10'h3FF};
    vecs[4] = '{2'd2, 10'h3FF, 10'h001, 10'h3FF, 10'h001};
    vecs[5] = '{2'd2, 10'h001, 10'h3FF, 10'h001, 10'h3FF};

    tick(3);
    for (int k = 0; k < 4; k++) begin
      check("rst_dout",   {22'd0, dout_v[k]}, 32'd0);
      check("rst_miso",   {31'd0, miso_v[k]}, 32'd0);
      check("rst_oe",     {31'd0, oe_v[k]},   32'd0);
      check("rst_busy",   {31'd0, busy_v[k]}, 32'd0);
      check("rst_rxdone", {31'd0, rxd_v[k]},  32'd0);
      check("rst_txload", {31'd0, txl_v[k]},  32'd0);
      check("rst_ferr",   {31'd0, fer_v[k]},  32'd0);
    end
    reset_n = 1'b1;
    tick(4);

    for (int v = 0; v < 6; v++) begin
      din = vecs[v].din;
      r0 = rxd_n[vecs[v].mode]; t0 = txl_n[vecs[v].mode]; f0 = fer_n[vecs[v].mode];
      spi_xfer(vecs[v].mode, 10, {10'h000, vecs[v].mtx}, 1'b0, rx);
      tick(6);
      $display("vec %0d mode %0d master_tx=%h slave_dout=%h master_rx=%h", v, vecs[v].mode,
               vecs[v].mtx, dout_v[vecs[v].mode], rx[9:0]);
      check("vec_dout",   {22'd0, dout_v[vecs[v].mode]}, {22'd0, vecs[v].exp_dout});
      check("vec_mrx",    {22'd0, rx[9:0]}, {22'd0, vecs[v].exp_mrx});
      check("vec_rxdone", rxd_n[vecs[v].mode] - r0, 32'd1);
      // one load at frame start plus one reload at the word boundary
      check("vec_txload", txl_n[vecs[v].mode] - t0, 32'd2);
      check("vec_ferr",   fer_n[vecs[v].mode] - f0, 32'd0);
      check("vec_busy",   {31'd0, busy_v[vecs[v].mode]}, 32'd0);
      check("vec_oe",     {31'd0, oe_v[vecs[v].mode]},   32'd0);
    end

    // Back-to-back, mode 0: next word presented after the first tx_load.
    din = 10'h111;
    r0 = rxd_n[0]; t0 = txl_n[0];
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          @(posedge clk); #1;
          if (txl_v[0]) begin
            din = 10'h222;
            break;
          end
        end
      end
    join_none
    spi_xfer(2'd0, 20, {10'h111, 10'h222}, 1'b0, rx);
    tick(6);
    $display("b2b mode 0 master_tx=111_222 slave_words=%h_%h master_rx=%h", hist0, hist1, rx);
    check("b2b_mrx",    {12'd0, rx}, {12'd0, 10'h111, 10'h222});
    check("b2b_word0",  {22'd0, hist0}, 32'h111);
    check("b2b_word1",  {22'd0, hist1}, 32'h222);
    check("b2b_rxdone", rxd_n[0] - r0, 32'd2);
    check("b2b_txload", txl_n[0] - t0, 32'd3);

    // Abort after 6 of 10 bits.
    din = 10'h3C3;
    r0 = rxd_n[0]; f0 = fer_n[0];
    spi_xfer(2'd0, 6, {14'h0000, 6'b101101}, 1'b0, rx);
    tick(4);
    check("abort_busy", {31'd0, busy_v[0]}, 32'd0);
    check("abort_oe",   {31'd0, oe_v[0]},   32'd0);
    tick(4);
    $display("abort mode 0 bits=6 master_rx=%h slave_dout=%h", rx[5:0], dout_v[0]);
    check("abort_mrx",    {26'd0, rx[5:0]}, 32'h3C);
    check("abort_ferr",   fer_n[0] - f0, 32'd1);
    check("abort_rxdone", rxd_n[0] - r0, 32'd0);
    check("abort_dout",   {22'd0, dout_v[0]}, 32'h222);

    // Reset in the middle of a frame, then a clean frame.
    din = 10'h155;
    r0 = rxd_n[0]; f0 = fer_n[0];
    spi_xfer(2'd0, 5, {15'h0000, 5'b10110}, 1'b1, rx);
    reset_n = 1'b0;
    #1;
    $display("reset mid-frame mode 0 dout=%h busy=%b oe=%b", dout_v[0], busy_v[0], oe_v[0]);
    check("mrst_dout",   {22'd0, dout_v[0]}, 32'd0);
    check("mrst_busy",   {31'd0, busy_v[0]}, 32'd0);
    check("mrst_oe",     {31'd0, oe_v[0]},   32'd0);
    check("mrst_miso",   {31'd0, miso_v[0]}, 32'd0);
    check("mrst_rxdone", {31'd0, rxd_v[0]},  32'd0);
    check("mrst_txload", {31'd0, txl_v[0]},  32'd0);
    check("mrst_ferr",   {31'd0, fer_v[0]},  32'd0);
    ss_n_m = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(6);
    check("mrst_no_ferr",   fer_n[0] - f0, 32'd0);
    check("mrst_no_rxdone", rxd_n[0] - r0, 32'd0);

    din = 10'h2C3;
    r0 = rxd_n[0];
    spi_xfer(2'd0, 10, {10'h000, 10'h0F0}, 1'b0, rx);
    tick(6);
    $display("post-reset mode 0 master_tx=0f0 slave_dout=%h master_rx=%h", dout_v[0], rx[9:0]);
    check("post_dout",   {22'd0, dout_v[0]}, 32'h0F0);
    check("post_mrx",    {22'd0, rx[9:0]}, 32'h2C3);
    check("post_rxdone", rxd_n[0] - r0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

endmodule
